// File: rtl/tick_scheduler.sv
// tick_scheduler: prescaled base tick plus NCH programmable one-cycle tick channels.
// Define TICK_SCHED_STATUS_EN to add the base_count / cfg_drop status outputs.
module tick_channel #(
  parameter int PW         = 16,
  parameter int DEF_PERIOD = 0
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  input  logic          wr,
  input  logic [PW-1:0] wr_period,
  output logic          sync,
  output logic          tick
);
  logic [PW-1:0] period, ccnt;
  logic          zero, hit;

  assign zero = (period == '0);
  assign hit  = !zero && (ccnt == period - PW'(1));
  // sync marks the base tick on which a deferred period write may land
  assign sync = adv && (zero || hit);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      period <= PW'(DEF_PERIOD);
      ccnt   <= '0;
      tick   <= 1'b0;
    end else begin
      tick <= adv && hit;
      if (clr || (adv && (zero || hit))) ccnt <= '0;
      else if (adv)                      ccnt <= ccnt + PW'(1);
      if (wr) begin
        period <= wr_period;
        ccnt   <= '0;
      end
    end
  end
endmodule

module tick_scheduler #(
  parameter  int PRESCALE   = 100000,
  parameter  int NCH        = 4,
  parameter  int PW         = 16,
  parameter  int DEF_PERIOD = 0,
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int PCW        = $clog2(PRESCALE)
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic           start,
  input  logic           pause,
  input  logic           stop,
  input  logic           cfg_valid,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [PW-1:0]  cfg_period,
  output logic           cfg_ready,
  output logic           base_tick,
  output logic [NCH-1:0] tick,
  output logic           running,
  output logic [1:0]     state
`ifdef TICK_SCHED_STATUS_EN
  ,
  output logic [15:0]    base_count,
  output logic           cfg_drop
`endif
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSED = 2'b10} st_t;

  st_t            st, st_nxt;
  logic [PCW-1:0] pcnt;
  logic           counting, clr, xfer, ch_ok, wr_now, pend_vld, pend_apply;
  logic [CW-1:0]  pend_ch;
  logic [PW-1:0]  pend_period, wr_period;
  logic [NCH-1:0] wr, sync;

  always_comb begin
    st_nxt = st;
    if (stop) st_nxt = S_IDLE;
    else begin
      case (st)
        S_IDLE:   if (start && !pause) st_nxt = S_RUN;
        S_RUN:    if (pause)           st_nxt = S_PAUSED;
        S_PAUSED: if (start && !pause) st_nxt = S_RUN;
        default:                       st_nxt = S_IDLE;
      endcase
    end
  end

  // The resume edge counts and the pause edge does not, so a pause shifts
  // the phase by exactly the number of PAUSED cycles.
  assign counting   = (st_nxt == S_RUN) && (st != S_IDLE);
  assign clr        = (st_nxt == S_IDLE);
  assign xfer       = cfg_valid && cfg_ready;
  assign ch_ok      = (32'(cfg_ch) < NCH);
  assign wr_now     = xfer && ch_ok && ((st != S_RUN) || (st_nxt != S_RUN));
  assign pend_apply = pend_vld && ((st_nxt != S_RUN) || sync[pend_ch]);
  assign wr_period  = pend_apply ? pend_period : cfg_period;
  assign state      = st;

  // A wrap caused by the last base tick before a pause still emits its tick.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr[i] = (wr_now && (cfg_ch == CW'(i))) || (pend_apply && (pend_ch == CW'(i)));
    tick_channel #(.PW(PW), .DEF_PERIOD(DEF_PERIOD)) u_ch (
      .clk_in    (clk_in),
      .reset     (reset),
      .clr       (clr),
      .adv       (base_tick && !clr),
      .wr        (wr[i]),
      .wr_period (wr_period),
      .sync      (sync[i]),
      .tick      (tick[i])
    );
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      st          <= S_IDLE;
      running     <= 1'b0;
      pcnt        <= '0;
      base_tick   <= 1'b0;
      cfg_ready   <= 1'b1;
      pend_vld    <= 1'b0;
      pend_ch     <= '0;
      pend_period <= '0;
    end else begin
      st        <= st_nxt;
      running   <= (st_nxt == S_RUN);
      base_tick <= counting && (pcnt == PCW'(PRESCALE - 1));
      if (clr)           pcnt <= '0;
      else if (counting) pcnt <= (pcnt == PCW'(PRESCALE - 1)) ? '0 : pcnt + PCW'(1);
      if (xfer && ch_ok && !wr_now) begin
        pend_vld    <= 1'b1;
        pend_ch     <= cfg_ch;
        pend_period <= cfg_period;
        cfg_ready   <= 1'b0;
      end else if (pend_apply) begin
        pend_vld  <= 1'b0;
        cfg_ready <= 1'b1;
      end
    end
  end

`ifdef TICK_SCHED_STATUS_EN
  always_ff @(posedge clk_in) begin
    if (reset) begin
      base_count <= '0;
      cfg_drop   <= 1'b0;
    end else begin
      cfg_drop <= xfer && !ch_ok;
      if (clr)                                       base_count <= '0;
      else if (base_tick && (base_count != 16'hFFFF)) base_count <= base_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_tick_scheduler.sv
// Directed + random bench for tick_scheduler against a cycle-level behavioural model.
module tb_tick_scheduler;
  localparam int P = 4;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         reset = 1'b1, start = 1'b0, pause = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
  logic [1:0]   cfg_ch = '0;
  logic [W-1:0] cfg_period = '0;
  logic         cfg_ready, base_tick, running;
  logic [N-1:0] tick;
  logic [1:0]   state;
`ifdef TICK_SCHED_STATUS_EN
  logic [15:0]  base_count;
  logic         cfg_drop;
`endif

  tick_scheduler #(.PRESCALE(P), .NCH(N), .PW(W), .DEF_PERIOD(0)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .cfg_valid  (cfg_valid),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_ready  (cfg_ready),
    .base_tick  (base_tick),
    .tick       (tick),
    .running    (running),
    .state      (state)
`ifdef TICK_SCHED_STATUS_EN
    ,
    .base_count (base_count),
    .cfg_drop   (cfg_drop)
`endif
  );

  always #5 clk_in = ~clk_in;

  int errors = 0, checks = 0, cyc = 0;
  int bt_q[$], t0_q[$], t1_q[$];

  // Reference model: phase from total counted RUN edges, channels count base ticks since last wrap.
  int   m_st, m_runs, m_per[N], m_nbt[N];
  logic m_bt, m_rdy;
  logic [N-1:0] m_tick;
  logic pend_v;
  int   pend_c, pend_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int nx;
    bit xfer, counting, new_bt;
    bit wrapped[N];
    logic [N-1:0] nt;
    if (reset) begin
      m_st = 0; m_runs = 0; m_bt = 0; m_tick = '0; m_rdy = 1; pend_v = 0;
      for (int i = 0; i < N; i++) begin m_per[i] = 0; m_nbt[i] = 0; end
    end else begin
      nx = m_st;
      if (stop) nx = 0;
      else if (m_st != 1 && start && !pause) nx = 1;
      else if (m_st == 1 && pause) nx = 2;
      xfer = cfg_valid && m_rdy;
      counting = (nx == 1) && (m_st != 0);
      new_bt = 0;
      nt = '0;
      if (nx == 0) m_runs = 0;
      else if (counting) begin
        m_runs++;
        new_bt = (m_runs % P == 0);
      end
      for (int i = 0; i < N; i++) begin
        wrapped[i] = 0;
        if (nx == 0) m_nbt[i] = 0;
        else if (m_bt && m_per[i] != 0) begin
          m_nbt[i]++;
          if (m_nbt[i] == m_per[i]) begin
            m_nbt[i] = 0; nt[i] = 1'b1; wrapped[i] = 1;
          end
        end
      end
      if (pend_v && (nx != 1 || wrapped[pend_c] || (m_bt && m_per[pend_c] == 0))) begin
        m_per[pend_c] = pend_p; m_nbt[pend_c] = 0; pend_v = 0; m_rdy = 1;
      end else if (xfer) begin
        if (m_st != 1 || nx != 1) begin
          m_per[cfg_ch] = int'(cfg_period); m_nbt[cfg_ch] = 0;
        end else begin
          pend_v = 1; pend_c = int'(cfg_ch); pend_p = int'(cfg_period); m_rdy = 0;
        end
      end
      m_bt = new_bt; m_tick = nt; m_st = nx;
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    cyc++;
    chk("state", 32'(state), 32'(m_st));
    chk("running", 32'(running), 32'(m_st == 1));
    chk("base_tick", 32'(base_tick), 32'(m_bt));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_rdy));
    if (base_tick) bt_q.push_back(cyc);
    if (tick[0])   t0_q.push_back(cyc);
    if (tick[1])   t1_q.push_back(cyc);
  endtask

  task automatic cfg_write(input int ch, input int per);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_period = 8'(per);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start(output int r);
    start = 1'b1; step(); start = 1'b0;
    r = cyc;
    bt_q.delete(); t0_q.delete(); t1_q.delete();
  endtask

  task automatic do_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  initial begin
    int r, lowcnt, guard;
    bit found;
    reset = 1'b1; step(); step(); reset = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_tick", 32'(tick), 32'd0);

    // ch0 period 3: base ticks every 4 cycles, tick[0] 13 cycles after running
    cfg_write(0, 3);
    do_start(r);
    chk("s1_running", 32'(running), 32'd1);
    repeat (26) step();
    chk("s1_first_bt", 32'(bt_q[0] - r), 32'd4);
    chk("s1_n_bt", 32'(bt_q.size()), 32'd6);
    chk("s1_n_t0", 32'(t0_q.size()), 32'd2);
    chk("s1_t0_a", 32'(t0_q[0] - r), 32'd13);
    chk("s1_t0_b", 32'(t0_q[1] - r), 32'd25);
    chk("s1_n_t1", 32'(t1_q.size()), 32'd0);

    // period 1 ticks after every base tick, period 0 never
    do_stop();
    cfg_write(0, 1); cfg_write(1, 0);
    do_start(r);
    repeat (41) step();
    chk("s2_n_t0", 32'(t0_q.size()), 32'd10);
    chk("s2_t0_first", 32'(t0_q[0] - r), 32'd5);
    chk("s2_n_t1", 32'(t1_q.size()), 32'd0);

    // pause 10 cycles: phase shifts by exactly that
    do_stop();
    cfg_write(0, 3);
    do_start(r);
    repeat (6) step();
    pause = 1'b1; repeat (10) step(); pause = 1'b0;
    chk("s3_paused", 32'(state), 32'd2);
    start = 1'b1; step(); start = 1'b0;
    repeat (20) step();
    chk("s3_bt0", 32'(bt_q[0] - r), 32'd4);
    chk("s3_bt1", 32'(bt_q[1] - r), 32'd18);
    chk("s3_t0", 32'(t0_q[0] - r), 32'd23);

    // deferred write in RUN lands on ch1's next wrap; second request held off
    do_stop();
    cfg_write(1, 5);
    do_start(r);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin step(); found = tick[1]; end
    chk("s4_tick1_seen", 32'(found), 32'd1);
    cfg_write(1, 2);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_period = 8'd3;
    lowcnt = 0; guard = 0;
    while (cfg_ready == 1'b0 && guard < 100) begin lowcnt++; guard++; step(); end
    chk("s4_ready_low", 32'(lowcnt), 32'd19);
    t1_q.delete();
    step();
    cfg_valid = 1'b0;
    chk("s4_second_held", 32'(cfg_ready), 32'd0);
    repeat (30) step();
    chk("s4_t1_spacing", 32'(t1_q[1] - t1_q[0]), 32'd8);

    // pending write flushed by stop
    guard = 0;
    while (cfg_ready == 1'b0 && guard < 100) begin guard++; step(); end
    chk("s5_ready_back", 32'(cfg_ready), 32'd1);
    cfg_write(0, 2);
    chk("s5_pending", 32'(cfg_ready), 32'd0);
    do_stop();
    chk("s5_idle", 32'(state), 32'd0);
    chk("s5_ready", 32'(cfg_ready), 32'd1);
    do_start(r);
    repeat (12) step();
    chk("s5_bt0", 32'(bt_q[0] - r), 32'd4);
    chk("s5_t0", 32'(t0_q[0] - r), 32'd9);

    // reset mid-RUN discards the pending write
    cfg_write(3, 1);
    chk("s6_pending", 32'(cfg_ready), 32'd0);
    reset = 1'b1; step(); reset = 1'b0;
    chk("s6_state", 32'(state), 32'd0);
    chk("s6_ready", 32'(cfg_ready), 32'd1);
    chk("s6_bt", 32'(base_tick), 32'd0);
    chk("s6_tick", 32'(tick), 32'd0);
    do_start(r);
    repeat (20) step();

    // random control and config traffic
    for (int k = 0; k < 600; k++) begin
      stop       = ($urandom % 60) == 0;
      pause      = ($urandom % 30) == 0;
      start      = ($urandom % 8) == 0;
      cfg_valid  = ($urandom % 5) == 0;
      cfg_ch     = 2'($urandom % N);
      cfg_period = 8'($urandom_range(0, 5));
      step();
    end
    stop = 1'b0; pause = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
